qpsk_frame_sequencer: RTL and testbench
=======================================

QPSK_FRAME_SEQUENCER -- requirements
Module: qpsk_frame_sequencer

Interface
REQ-001 Parameter PREAMBLE, default 8'h78, is the preamble byte pattern, sent LSB first.
REQ-002 Parameter PRE_LEN, default 2, is the number of preamble bytes per frame (1..15).
REQ-003 Parameter SYM_DIV, default 4, is the number of clocks per symbol (2..255).
REQ-004 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port RST_N, input, 1: asynchronous, active-low reset.
REQ-006 Port START, input, 1: frame request, sampled in IDLE.
REQ-007 Port LEN, input, 8: payload byte count, sampled with START.
REQ-008 Port DIN, input, 8: payload byte from the upstream requester.
REQ-009 Port DIN_VALID, input, 1: DIN holds a valid byte.
REQ-010 Port DIN_READY, output, 1: sequencer accepts DIN this cycle.
REQ-011 Port SYM_EN, output, 1: one-cycle strobe marking a new symbol on I/Q.
REQ-012 Port I, output, 1: in-phase bit of the current symbol.
REQ-013 Port Q, output, 1: quadrature bit of the current symbol.
REQ-014 Port BUSY, output, 1: high from START acceptance until DONE.
REQ-015 Port DONE, output, 1: one-cycle pulse after the last payload symbol period.
REQ-016 Port UNDERRUN, output, 1: sticky flag, set when a pad symbol is inserted.

Function
REQ-017 States SHALL be IDLE, PRE, PAY and FIN.
- IDLE->PRE: START=1 and LEN!=0; LEN is latched.
- START with LEN=0, or START outside IDLE: ignored, no flag.
REQ-018 The symbol timer SHALL run only outside IDLE and count 0..SYM_DIV-1.
- SYM_EN=1 on the cycle the timer equals 0.
- The first SYM_EN occurs the cycle after START acceptance.
REQ-019 Each byte SHALL yield 4 symbols, LSB first: symbol k gives I=byte[2k], Q=byte[2k+1].
- I/Q update on the SYM_EN cycle and hold for SYM_DIV clocks.
REQ-020 PRE SHALL emit PRE_LEN*4 symbols of PREAMBLE, then go to PAY on the next symbol boundary.
REQ-021 Holding buffer: 1 byte.
- DIN_READY = (PRE or PAY) and buffer empty and bytes_accepted < LEN.
- A byte is accepted only when DIN_VALID and DIN_READY are both 1 in the same cycle.
REQ-022 At each PAY byte boundary, a full buffer SHALL move into the shift register; bytes_sent increments.
REQ-023 At a PAY byte boundary with an empty buffer, the sequencer SHALL emit 4 pad symbols (I=0, Q=0) and set UNDERRUN.
- bytes_sent is not incremented for pad symbols.
REQ-024 After symbol 3 of byte LEN, the FSM SHALL move PAY->FIN at the end of that symbol period.
- In FIN: DONE=1 for one cycle, BUSY=0, then IDLE.
- START in the FIN cycle is ignored.
REQ-025 A byte accepted in the same cycle the buffer is emptied SHALL be stored without loss (simultaneous load/unload).
REQ-026 Byte counters SHALL be 8 bits; LEN=255 completes without wrap.
REQ-027 UNDERRUN SHALL clear only on reset or on the next accepted START.
REQ-028 Outputs SHALL be registered; no combinational path from DIN_VALID to DIN_READY.

Reset
REQ-029 RST_N=0 SHALL immediately force IDLE and clear all counters, the buffer, the shift register and UNDERRUN.
- Outputs: DIN_READY=0, SYM_EN=0, I=0, Q=0, BUSY=0, DONE=0, UNDERRUN=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no DONE pulse.
- After release, the block waits in IDLE for a new START.

Verification
REQ-031 Default parameters, LEN=1, DIN=8'hB4 always valid -> 8 preamble symbols (I,Q) = (0,0),(0,1),(1,1),(1,0) twice, then (0,0),(1,0),(1,1),(0,1); DONE 48 clocks after the first SYM_EN; UNDERRUN=0.
REQ-032 LEN=0 with START=1 -> BUSY stays 0, no SYM_EN, DIN_READY stays 0.
REQ-033 LEN=2, DIN_VALID withheld until after the PAY boundary -> 4 (0,0) pad symbols, UNDERRUN=1, both bytes still sent, DONE follows.
REQ-034 RST_N=0 during the payload of LEN=3 -> all outputs 0 in the same cycle, no DONE; a following START with LEN=1 runs a normal frame.
REQ-035 START pulsed while BUSY, with different LEN -> ignored; original frame length is preserved.
REQ-036 LEN=255, continuous DIN_VALID -> exactly 255 bytes accepted, 1028 symbols total, single DONE.

Source files
------------

// File: rtl/qpsk_frame_if.sv
// QPSK frame sequencer bus: requester side drives START/LEN/DIN,
// sequencer side drives the handshake ready, symbol outputs and status.
interface qpsk_frame_if;
   logic       START;
   logic [7:0] LEN;
   logic [7:0] DIN;
   logic       DIN_VALID;
   logic       DIN_READY;
   logic       SYM_EN;
   logic       I;
   logic       Q;
   logic       BUSY;
   logic       DONE;
   logic       UNDERRUN;

   modport master (
      output START, LEN, DIN, DIN_VALID,
      input  DIN_READY, SYM_EN, I, Q,
      input  BUSY, DONE, UNDERRUN
   );

   modport slave (
      input  START, LEN, DIN, DIN_VALID,
      output DIN_READY, SYM_EN, I, Q,
      output BUSY, DONE, UNDERRUN
   );
endinterface

// File: rtl/qpsk_frame_sequencer.sv
// QPSK frame sequencer: preamble bytes then payload bytes, 2 bits
// per symbol LSB first, with a 1-byte holding buffer and pad on underrun.
module qpsk_frame_sequencer #(
   parameter logic [7:0]  PREAMBLE = 8'h78,
   parameter int unsigned PRE_LEN  = 2,
   parameter int unsigned SYM_DIV  = 4
) (
   input logic         CLK,
   input logic         RST_N,
   qpsk_frame_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PRE, PAY, FIN} state_e;

   localparam logic [7:0] TMR_LAST = 8'(SYM_DIV - 1);
   localparam logic [3:0] PRE_LAST = 4'(PRE_LEN - 1);

   state_e     state_q, state_d;
   logic [7:0] tmr_q, tmr_d;
   logic [1:0] sidx_q, sidx_d;
   logic [3:0] pre_q, pre_d;
   logic [7:0] len_q, len_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] sent_q, sent_d;
   logic [7:0] hold_q, hold_d;
   logic       hfull_q, hfull_d;
   logic [7:0] sh_q, sh_d;
   logic       pad_q, pad_d;
   logic       rdy_q, rdy_d;
   logic       sym_q, sym_d;
   logic       i_q, i_d;
   logic       q_q, q_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       unr_q, unr_d;

   logic       accept;
   logic       sym_start;
   logic       load_new;
   logic       unload;
   logic       run;
   logic [7:0] new_byte;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         sidx_q  <= '0;
         pre_q   <= '0;
         len_q   <= '0;
         acc_q   <= '0;
         sent_q  <= '0;
         hold_q  <= '0;
         hfull_q <= 1'b0;
         sh_q    <= '0;
         pad_q   <= 1'b0;
         rdy_q   <= 1'b0;
         sym_q   <= 1'b0;
         i_q     <= 1'b0;
         q_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         unr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         sidx_q  <= sidx_d;
         pre_q   <= pre_d;
         len_q   <= len_d;
         acc_q   <= acc_d;
         sent_q  <= sent_d;
         hold_q  <= hold_d;
         hfull_q <= hfull_d;
         sh_q    <= sh_d;
         pad_q   <= pad_d;
         rdy_q   <= rdy_d;
         sym_q   <= sym_d;
         i_q     <= i_d;
         q_q     <= q_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         unr_q   <= unr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      sidx_d    = sidx_q;
      pre_d     = pre_q;
      len_d     = len_q;
      acc_d     = acc_q;
      sent_d    = sent_q;
      pad_d     = pad_q;
      unr_d     = unr_q;
      sh_d      = sh_q;
      i_d       = i_q;
      q_d       = q_q;
      sym_start = 1'b0;
      load_new  = 1'b0;
      unload    = 1'b0;
      new_byte  = PREAMBLE;
      accept    = bus.DIN_VALID & rdy_q;
      hold_d    = accept ? bus.DIN : hold_q;
      if (accept) acc_d = acc_q + 8'd1;

      unique case (state_q)
         IDLE: begin
            if (bus.START && bus.LEN != 8'd0) begin
               state_d   = PRE;
               len_d     = bus.LEN;
               acc_d     = '0;
               sent_d    = '0;
               pre_d     = '0;
               sidx_d    = '0;
               tmr_d     = '0;
               pad_d     = 1'b0;
               unr_d     = 1'b0;
               sym_start = 1'b1;
               load_new  = 1'b1;
            end
         end
         PRE, PAY: begin
            tmr_d = (tmr_q == TMR_LAST) ? 8'd0 : tmr_q + 8'd1;
            if (tmr_q == TMR_LAST) begin
               sym_start = 1'b1;
               sidx_d    = sidx_q + 2'd1;
               if (sidx_q == 2'd3) begin
                  load_new = 1'b1;
                  if (state_q == PRE && pre_q != PRE_LAST) begin
                     pre_d = pre_q + 4'd1;
                  end else if (state_q == PAY && !pad_q
                               && sent_q == len_q) begin
                     state_d   = FIN;
                     sym_start = 1'b0;
                     load_new  = 1'b0;
                  end else begin
                     // Byte boundary: take the buffered byte or pad.
                     state_d  = PAY;
                     unload   = hfull_q;
                     pad_d    = !hfull_q;
                     new_byte = hfull_q ? hold_q : 8'h00;
                     if (hfull_q) sent_d = sent_q + 8'd1;
                     else         unr_d  = 1'b1;
                  end
               end
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      hfull_d = accept | (hfull_q & ~unload);

      if (sym_start) begin
         if (load_new) begin
            i_d  = new_byte[0];
            q_d  = new_byte[1];
            sh_d = {2'b00, new_byte[7:2]};
         end else begin
            i_d  = sh_q[0];
            q_d  = sh_q[1];
            sh_d = {2'b00, sh_q[7:2]};
         end
      end

      run    = (state_d == PRE) || (state_d == PAY);
      sym_d  = sym_start;
      busy_d = run;
      done_d = (state_d == FIN);
      rdy_d  = run & ~hfull_d & (acc_d < len_d);
   end

   assign bus.DIN_READY = rdy_q;
   assign bus.SYM_EN    = sym_q;
   assign bus.I         = i_q;
   assign bus.Q         = q_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.UNDERRUN  = unr_q;
endmodule

// File: tb/tb_qpsk_frame_sequencer.sv
// Bench for qpsk_frame_sequencer: directed frame table, hand-written
// corner sequences and random frames checked against a symbol-stream model.
module tb_qpsk_frame_sequencer;
   localparam logic [7:0] PRE = 8'h78;
   localparam int PL = 2;
   localparam int SD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   qpsk_frame_if bus ();

   qpsk_frame_sequencer #(
      .PREAMBLE(PRE), .PRE_LEN(PL), .SYM_DIV(SD)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .bus(bus.slave)
   );

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      int         len;
      int         hold;
      int         pct;
      int         poke;
      logic [7:0] b0;
      int         nsym;
      bit         unr;
   } vec_t;

   vec_t vecs[6];

   int         acc_e[$];
   logic [7:0] acc_b[$];
   int         sym_e[$];
   logic [1:0] sym_iq[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int outs_word();
      return int'({bus.DIN_READY, bus.SYM_EN, bus.I, bus.Q,
                   bus.BUSY, bus.DONE, bus.UNDERRUN});
   endfunction

   // Drives one frame, records what the DUT emits, then rebuilds the
   // expected symbol stream from the byte acceptance times alone.
   task automatic run_frame(input string tag, input int len,
         input int hold, input int pct, input int poke,
         input logic [7:0] b0, input int nsym, input bit unr);
      logic [7:0] data[$];
      int         exp_e[$];
      logic [1:0] exp_iq[$];
      int k, idx, done_n, done_k, limit;
      int t, used, pads, avail, exp_done, bad;
      bit unr_at_done, busy_at_done, busy_bad, v;
      logic [7:0] b;

      data.delete();
      acc_e.delete();
      acc_b.delete();
      sym_e.delete();
      sym_iq.delete();
      for (int i = 0; i < len; i++)
         data.push_back((i == 0 && b0 != 8'h00) ? b0
                        : 8'($urandom_range(1, 255)));

      @(negedge clk);
      bus.START = 1'b1;
      bus.LEN = 8'(len);
      bus.DIN_VALID = 1'b0;
      k = 0;
      idx = 0;
      done_n = 0;
      done_k = -1;
      busy_bad = 1'b0;
      unr_at_done = 1'b0;
      busy_at_done = 1'b0;
      limit = 400 + 64 * len + hold;
      while (k < limit && !(done_n > 0 && k > done_k + 2 * SD + 4)) begin
         @(negedge clk);
         k++;
         bus.START = (k == poke);
         bus.LEN = (k == poke) ? 8'(len + 3) : 8'(len);
         if (bus.SYM_EN) begin
            sym_e.push_back(k);
            sym_iq.push_back({bus.I, bus.Q});
            if (!bus.BUSY) busy_bad = 1'b1;
         end
         if (bus.DONE) begin
            done_n++;
            if (done_n == 1) begin
               done_k = k;
               unr_at_done = bus.UNDERRUN;
               busy_at_done = bus.BUSY;
            end
         end
         v = (idx < len) && (k >= hold)
             && ($urandom_range(0, 99) < pct);
         bus.DIN_VALID = v;
         bus.DIN = (idx < len) ? data[idx] : 8'h00;
         if (v && bus.DIN_READY) begin
            acc_e.push_back(k + 1);
            acc_b.push_back(data[idx]);
            idx++;
         end
      end
      bus.DIN_VALID = 1'b0;
      bus.START = 1'b0;
      if (k >= limit && done_n == 0)
         $display("FAIL %s timeout: no DONE within %0d cycles", tag, limit);

      // Symbol t starts SD*t edges after the first; a byte can fill a
      // group only if it was accepted on an earlier edge than the group.
      t = 0;
      for (int p = 0; p < PL; p++) begin
         b = PRE;
         for (int j = 0; j < 4; j++) begin
            exp_e.push_back(1 + t * SD);
            exp_iq.push_back({b[2*j], b[2*j+1]});
            t++;
         end
      end
      used = 0;
      pads = 0;
      while (used < len && t < 4 * (PL + len) + 400) begin
         avail = 0;
         foreach (acc_e[i]) if (acc_e[i] < 1 + t * SD) avail++;
         if (avail > used) begin
            b = acc_b[used];
            used++;
         end else begin
            b = 8'h00;
            pads++;
         end
         for (int j = 0; j < 4; j++) begin
            exp_e.push_back(1 + t * SD);
            exp_iq.push_back({b[2*j], b[2*j+1]});
            t++;
         end
      end
      exp_done = 1 + t * SD;

      bad = -1;
      for (int i = 0; i < exp_e.size(); i++)
         if (bad < 0 && (i >= sym_e.size() || sym_e[i] != exp_e[i]
                         || sym_iq[i] != exp_iq[i]))
            bad = i;

      chk({tag, " first SYM_EN edge"},
          (sym_e.size() > 0) ? sym_e[0] : -1, 1);
      chk({tag, " bytes accepted"}, acc_e.size(), len);
      chk({tag, " symbol count"}, sym_e.size(), exp_e.size());
      chk({tag, " first bad symbol index"}, bad, -1);
      chk({tag, " DONE edge"}, done_k, exp_done);
      chk({tag, " DONE pulses"}, done_n, 1);
      chk({tag, " UNDERRUN at DONE"}, int'(unr_at_done), int'(pads > 0));
      chk({tag, " BUSY low at DONE, high on SYM_EN"},
          int'(busy_at_done | busy_bad), 0);
      if (nsym >= 0) begin
         chk({tag, " table symbol count"}, sym_e.size(), nsym);
         chk({tag, " table UNDERRUN"}, int'(unr_at_done), int'(unr));
      end
   endtask

   bit seen;

   initial begin
      vecs[0] = '{len:1, hold:0,  pct:100, poke:-1, b0:8'hB4, nsym:12, unr:0};
      vecs[1] = '{len:2, hold:40, pct:100, poke:-1, b0:8'h00, nsym:20, unr:1};
      vecs[2] = '{len:3, hold:0,  pct:100, poke:-1, b0:8'h00, nsym:20, unr:0};
      vecs[3] = '{len:1, hold:60, pct:100, poke:-1, b0:8'h00, nsym:20, unr:1};
      vecs[4] = '{len:4, hold:0,  pct:100, poke:-1, b0:8'h00, nsym:24, unr:0};
      vecs[5] = '{len:2, hold:0,  pct:100, poke:20, b0:8'h00, nsym:16, unr:0};

      bus.START = 1'b0;
      bus.LEN = 8'h00;
      bus.DIN = 8'h00;
      bus.DIN_VALID = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset outputs", outs_word(), 0);
      rst_n = 1'b1;

      @(negedge clk);
      bus.START = 1'b1;
      bus.LEN = 8'h00;
      bus.DIN_VALID = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         bus.START = 1'b0;
         seen = seen | bus.BUSY | bus.SYM_EN | bus.DIN_READY;
      end
      bus.DIN_VALID = 1'b0;
      chk("LEN=0 START ignored", int'(seen), 0);

      for (int i = 0; i < 6; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].hold,
                   vecs[i].pct, vecs[i].poke, vecs[i].b0,
                   vecs[i].nsym, vecs[i].unr);

      @(negedge clk);
      bus.START = 1'b1;
      bus.LEN = 8'd3;
      bus.DIN = 8'h5A;
      bus.DIN_VALID = 1'b1;
      @(negedge clk);
      bus.START = 1'b0;
      repeat (44) @(negedge clk);
      chk("busy before mid-frame reset", int'(bus.BUSY), 1);
      rst_n = 1'b0;
      #1;
      chk("mid-frame reset outputs", outs_word(), 0);
      bus.DIN_VALID = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | bus.DONE | bus.BUSY;
      end
      rst_n = 1'b1;
      repeat (100) begin
         @(negedge clk);
         seen = seen | bus.DONE | bus.BUSY | bus.SYM_EN;
      end
      chk("idle after aborted frame", int'(seen), 0);
      run_frame("after reset", 1, 0, 100, -1, 8'hB4, 12, 1'b0);

      run_frame("len255", 255, 0, 100, -1, 8'h00, 1028, 1'b0);

      for (int r = 0; r < 8; r++)
         run_frame($sformatf("rand%0d", r), $urandom_range(1, 10),
                   $urandom_range(0, 50), $urandom_range(30, 100),
                   -1, 8'h00, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
